// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one synchronous memory between a CPU and a DMA engine.
// Each granted access holds the memory bus for ACC_CYCLES cycles, then pulses done/ack for one cycle.
module mem_arbiter #(
  parameter int ACC_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [11:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [11:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_done,
  output logic [15:0] dma_rdata,
  output logic        dma_ack,
  output logic        wait_
);

  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;
  typedef enum logic {GRANT_CPU = 1'b0, GRANT_DMA = 1'b1} grant_t;

  localparam logic [2:0] LAST_CNT = 3'(ACC_CYCLES - 1);

  state_t     state;
  grant_t     last_grant;
  logic [2:0] cnt;
  logic       cpu_elig;
  logic       dma_elig;
  logic       pick_dma;

  // A requester whose completion pulse is showing this cycle sits out one arbitration round.
  assign cpu_elig = cpu_req & ~cpu_done;
  assign dma_elig = dma_req & ~dma_ack;
  assign pick_dma = dma_elig & (~cpu_elig | (last_grant == GRANT_CPU));
  assign wait_    = cpu_req & ~cpu_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_grant <= GRANT_DMA;
      cnt        <= 3'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 12'd0;
      mem_wdata  <= 16'd0;
      cpu_rdata  <= 16'd0;
      dma_rdata  <= 16'd0;
      cpu_done   <= 1'b0;
      dma_ack    <= 1'b0;
    end else begin
      cpu_done <= 1'b0;
      dma_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_elig | dma_elig) begin
            cnt    <= 3'd0;
            mem_en <= 1'b1;
            if (pick_dma) begin
              state      <= DMA_ACC;
              last_grant <= GRANT_DMA;
              mem_we     <= dma_we;
              mem_addr   <= dma_addr;
              mem_wdata  <= dma_wdata;
            end else begin
              state      <= CPU_ACC;
              last_grant <= GRANT_CPU;
              mem_we     <= cpu_we;
              mem_addr   <= cpu_addr;
              mem_wdata  <= cpu_wdata;
            end
          end
        end
        CPU_ACC, DMA_ACC: begin
          if (cnt == LAST_CNT) begin
            // Final access cycle: capture read data, pulse completion, release the bus.
            if (!mem_we) begin
              if (state == CPU_ACC) cpu_rdata <= mem_rdata;
              else                  dma_rdata <= mem_rdata;
            end
            if (state == CPU_ACC) cpu_done <= 1'b1;
            else                  dma_ack  <= 1'b1;
            state  <= IDLE;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            cnt    <= 3'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: two instances (ACC_CYCLES=2 and 1) checked against a transaction-level model,
// plus a fixed vector table and hand-written reset / latency sequences.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, cpu_req, cpu_we, dma_req, dma_we;
  logic [11:0] cpu_addr, dma_addr;
  logic [15:0] cpu_wdata, dma_wdata;
  logic [1:0]  mem_en, mem_we, cpu_done, dma_ack, wait_;
  logic [11:0] mem_addr  [2];
  logic [15:0] mem_wdata [2];
  logic [15:0] mem_rdata [2];
  logic [15:0] cpu_rdata [2];
  logic [15:0] dma_rdata [2];

  int tests = 0;
  int fails = 0;

  // Memory contents are a fixed function of address; 0x0A5 reads 0x1234.
  function automatic logic [15:0] hash(input logic [11:0] a);
    return {a[3:0], a} ^ 16'h4291;
  endfunction

  assign mem_rdata[0] = hash(mem_addr[0]);
  assign mem_rdata[1] = hash(mem_addr[1]);

  mem_arbiter #(.ACC_CYCLES(2)) dut0 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .mem_rdata(mem_rdata[0]), .cpu_rdata(cpu_rdata[0]), .cpu_done(cpu_done[0]),
    .dma_rdata(dma_rdata[0]), .dma_ack(dma_ack[0]), .wait_(wait_[0])
  );

  mem_arbiter #(.ACC_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .mem_rdata(mem_rdata[1]), .cpu_rdata(cpu_rdata[1]), .cpu_done(cpu_done[1]),
    .dma_rdata(dma_rdata[1]), .dma_ack(dma_ack[1]), .wait_(wait_[1])
  );

  // Reference model: an access is a transaction with an owner and a countdown of remaining cycles.
  typedef struct {
    int          acc;
    bit          busy;
    bit          who;     // 0 = CPU, 1 = DMA
    int          left;
    logic [11:0] a;
    logic [15:0] d;
    bit          we;
    bit          last;
    bit          cd;
    bit          da;
    logic [15:0] crd;
    logic [15:0] drd;
  } mdl_t;

  mdl_t m [2];

  task automatic model_reset(input int i);
    m[i].busy = 0; m[i].who = 0; m[i].left = 0;
    m[i].a = '0; m[i].d = '0; m[i].we = 0;
    m[i].last = 1; m[i].cd = 0; m[i].da = 0;
    m[i].crd = '0; m[i].drd = '0;
  endtask

  task automatic model_step(input int i);
    bit ec, ed, win;
    if (!reset_n) begin
      model_reset(i);
      return;
    end
    ec = cpu_req && !m[i].cd;
    ed = dma_req && !m[i].da;
    m[i].cd = 0;
    m[i].da = 0;
    if (m[i].busy) begin
      m[i].left = m[i].left - 1;
      if (m[i].left == 0) begin
        m[i].busy = 0;
        if (m[i].who == 0) begin
          m[i].cd = 1;
          if (!m[i].we) m[i].crd = hash(m[i].a);
        end else begin
          m[i].da = 1;
          if (!m[i].we) m[i].drd = hash(m[i].a);
        end
      end
    end else if (ec || ed) begin
      win = (ec && ed) ? !m[i].last : ed;
      m[i].who  = win;
      m[i].a    = win ? dma_addr  : cpu_addr;
      m[i].d    = win ? dma_wdata : cpu_wdata;
      m[i].we   = win ? dma_we    : cpu_we;
      m[i].busy = 1;
      m[i].left = m[i].acc;
      m[i].last = win;
    end
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model(input int i);
    chk($sformatf("d%0d mem_en", i),    16'(mem_en[i]),   16'(m[i].busy));
    chk($sformatf("d%0d mem_we", i),    16'(mem_we[i]),   16'(m[i].busy & m[i].we));
    chk($sformatf("d%0d mem_addr", i),  16'(mem_addr[i]), 16'(m[i].a));
    chk($sformatf("d%0d mem_wdata", i), mem_wdata[i],     m[i].d);
    chk($sformatf("d%0d cpu_done", i),  16'(cpu_done[i]), 16'(m[i].cd));
    chk($sformatf("d%0d dma_ack", i),   16'(dma_ack[i]),  16'(m[i].da));
    chk($sformatf("d%0d wait_", i),     16'(wait_[i]),    16'(cpu_req & ~m[i].cd));
    chk($sformatf("d%0d cpu_rdata", i), cpu_rdata[i],     m[i].crd);
    chk($sformatf("d%0d dma_rdata", i), dma_rdata[i],     m[i].drd);
  endtask

  // Called at the falling edge: compare, advance the models across the coming edge, resume after it.
  task automatic tick();
    for (int i = 0; i < 2; i++) check_model(i);
    for (int i = 0; i < 2; i++) model_step(i);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        creq, dreq;
    logic [11:0] daddr;
    logic        en, we;
    logic [11:0] addr;
    logic [15:0] wd;
    logic        cd, da, wt;
    logic [15:0] crd, drd;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic creq, input logic dreq, input logic [11:0] daddr,
                              input logic en, input logic we, input logic [11:0] addr,
                              input logic [15:0] wd, input logic cd, input logic da,
                              input logic wt, input logic [15:0] crd, input logic [15:0] drd);
    vec_t v;
    v.creq = creq; v.dreq = dreq; v.daddr = daddr; v.en = en; v.we = we; v.addr = addr;
    v.wd = wd; v.cd = cd; v.da = da; v.wt = wt; v.crd = crd; v.drd = drd;
    return v;
  endfunction

  int cd_at0, cd_at1, en_cnt0, en_cnt1;

  initial begin
    // Table for the ACC_CYCLES=2 instance: tie, DMA write with address change, alternation, held cpu_req.
    //            creq dreq daddr   en we addr    wdata     cd da wt crd       drd
    tbl[0]  = mk(1, 1, 12'h3FF, 0, 0, 12'h000, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000);
    tbl[1]  = mk(1, 1, 12'h3FF, 1, 0, 12'h0A5, 16'h5555, 0, 0, 1, 16'h0000, 16'h0000);
    tbl[2]  = mk(1, 1, 12'h3FF, 1, 0, 12'h0A5, 16'h5555, 0, 0, 1, 16'h0000, 16'h0000);
    tbl[3]  = mk(1, 1, 12'h3FF, 0, 0, 12'h0A5, 16'h5555, 1, 0, 0, 16'h1234, 16'h0000);
    tbl[4]  = mk(0, 1, 12'h000, 1, 1, 12'h3FF, 16'hBEEF, 0, 0, 0, 16'h1234, 16'h0000);
    tbl[5]  = mk(0, 1, 12'h000, 1, 1, 12'h3FF, 16'hBEEF, 0, 0, 0, 16'h1234, 16'h0000);
    tbl[6]  = mk(0, 0, 12'h3FF, 0, 0, 12'h3FF, 16'hBEEF, 0, 1, 0, 16'h1234, 16'h0000);
    tbl[7]  = mk(0, 0, 12'h3FF, 0, 0, 12'h3FF, 16'hBEEF, 0, 0, 0, 16'h1234, 16'h0000);
    tbl[8]  = mk(1, 1, 12'h3FF, 0, 0, 12'h3FF, 16'hBEEF, 0, 0, 1, 16'h1234, 16'h0000);
    tbl[9]  = mk(1, 1, 12'h3FF, 1, 0, 12'h0A5, 16'h5555, 0, 0, 1, 16'h1234, 16'h0000);
    tbl[10] = mk(1, 0, 12'h3FF, 1, 0, 12'h0A5, 16'h5555, 0, 0, 1, 16'h1234, 16'h0000);
    tbl[11] = mk(1, 0, 12'h3FF, 0, 0, 12'h0A5, 16'h5555, 1, 0, 0, 16'h1234, 16'h0000);
    tbl[12] = mk(1, 0, 12'h3FF, 0, 0, 12'h0A5, 16'h5555, 0, 0, 1, 16'h1234, 16'h0000);
    tbl[13] = mk(0, 0, 12'h3FF, 1, 0, 12'h0A5, 16'h5555, 0, 0, 0, 16'h1234, 16'h0000);
    tbl[14] = mk(0, 0, 12'h3FF, 1, 0, 12'h0A5, 16'h5555, 0, 0, 0, 16'h1234, 16'h0000);
    tbl[15] = mk(0, 0, 12'h3FF, 0, 0, 12'h0A5, 16'h5555, 1, 0, 0, 16'h1234, 16'h0000);
    tbl[16] = mk(0, 0, 12'h3FF, 0, 0, 12'h0A5, 16'h5555, 0, 0, 0, 16'h1234, 16'h0000);

    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 12'h0A5; cpu_wdata = 16'h5555;
    dma_req = 1'b0; dma_we = 1'b1; dma_addr = 12'h3FF; dma_wdata = 16'hBEEF;
    m[0].acc = 2;
    m[1].acc = 1;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    tick();
    reset_n = 1'b1;

    for (int k = 0; k < 17; k++) begin
      cpu_req  = tbl[k].creq;
      dma_req  = tbl[k].dreq;
      dma_addr = tbl[k].daddr;
      @(negedge clk);
      chk($sformatf("tbl%0d mem_en", k),    16'(mem_en[0]),   16'(tbl[k].en));
      chk($sformatf("tbl%0d mem_we", k),    16'(mem_we[0]),   16'(tbl[k].we));
      chk($sformatf("tbl%0d mem_addr", k),  16'(mem_addr[0]), 16'(tbl[k].addr));
      chk($sformatf("tbl%0d mem_wdata", k), mem_wdata[0],     tbl[k].wd);
      chk($sformatf("tbl%0d cpu_done", k),  16'(cpu_done[0]), 16'(tbl[k].cd));
      chk($sformatf("tbl%0d dma_ack", k),   16'(dma_ack[0]),  16'(tbl[k].da));
      chk($sformatf("tbl%0d wait_", k),     16'(wait_[0]),    16'(tbl[k].wt));
      chk($sformatf("tbl%0d cpu_rdata", k), cpu_rdata[0],     tbl[k].crd);
      chk($sformatf("tbl%0d dma_rdata", k), dma_rdata[0],     tbl[k].drd);
      tick();
    end

    // Reset asserted in the second cycle of a CPU read: everything clears at once, no completion.
    cpu_req = 1'b1;
    dma_req = 1'b0;
    @(negedge clk);
    tick();
    @(negedge clk);
    tick();
    #1;
    reset_n = 1'b0;
    model_reset(0);
    model_reset(1);
    #1;
    chk("rst mem_en",    16'(mem_en[0]),   16'h0000);
    chk("rst mem_we",    16'(mem_we[0]),   16'h0000);
    chk("rst mem_addr",  16'(mem_addr[0]), 16'h0000);
    chk("rst mem_wdata", mem_wdata[0],     16'h0000);
    chk("rst cpu_rdata", cpu_rdata[0],     16'h0000);
    chk("rst cpu_done",  16'(cpu_done[0]), 16'h0000);
    chk("rst wait_",     16'(wait_[0]),    16'h0001);
    @(negedge clk);
    tick();

    // Re-request after reset: latency ACC_CYCLES+1, bus held ACC_CYCLES cycles.
    reset_n = 1'b1;
    cd_at0 = -1; cd_at1 = -1; en_cnt0 = 0; en_cnt1 = 0;
    for (int c = 0; c < 6; c++) begin
      cpu_req = (c < 2);
      @(negedge clk);
      if (cpu_done[0] && cd_at0 < 0) cd_at0 = c;
      if (cpu_done[1] && cd_at1 < 0) cd_at1 = c;
      en_cnt0 += int'(mem_en[0]);
      en_cnt1 += int'(mem_en[1]);
      tick();
    end
    chk("lat acc2 done cycle", 16'(cd_at0), 16'd3);
    chk("lat acc1 done cycle", 16'(cd_at1), 16'd2);
    chk("lat acc2 en cycles",  16'(en_cnt0), 16'd2);
    chk("lat acc1 en cycles",  16'(en_cnt1), 16'd1);
    chk("lat acc2 rdata",      cpu_rdata[0], 16'h1234);

    // Randomized traffic against the model, with occasional resets.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(63) == 0) begin
        reset_n = 1'b0;
        model_reset(0);
        model_reset(1);
      end else begin
        reset_n = 1'b1;
      end
      cpu_req   = ($urandom_range(2) != 0);
      cpu_we    = $urandom_range(1) == 1;
      cpu_addr  = 12'($urandom);
      cpu_wdata = 16'($urandom);
      dma_req   = ($urandom_range(2) != 0);
      dma_we    = $urandom_range(1) == 1;
      dma_addr  = 12'($urandom);
      dma_wdata = 16'($urandom);
      @(negedge clk);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
